// File: rtl/pcm_dc_block_fifo_pkg.sv
// Shared PCM types, limits and the saturation helper used by the
// post-decimator audio stage.
package pcm_dc_block_fifo_pkg;

    localparam int PCM_W    = 16;
    localparam int SAT_IN_W = 64;

    typedef logic signed [PCM_W-1:0] pcm_t;

    localparam pcm_t PCM_MAX = 16'sh7FFF;
    localparam pcm_t PCM_MIN = 16'sh8000;

    // Callers sign-extend their wide intermediate into SAT_IN_W bits.
    function automatic pcm_t sat16(input logic signed [SAT_IN_W-1:0] v);
        pcm_t r;
        if (v > SAT_IN_W'(PCM_MAX)) begin
            r = PCM_MAX;
        end else if (v < SAT_IN_W'(PCM_MIN)) begin
            r = PCM_MIN;
        end else begin
            r = v[PCM_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pcm_dc_block_fifo_if.sv
// Sample path of the DC-block stage: decimator word and strobe in,
// valid/ready PCM stream out toward the audio sink.
interface pcm_dc_block_fifo_if;
    import pcm_dc_block_fifo_pkg::*;

    logic [PCM_W-1:0] in_data;
    logic             in_en;
    logic [2:0]       gain_sh;
    pcm_t             out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_en,
        output gain_sh,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_en,
        input  gain_sh,
        input  out_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/pcm_dc_block_fifo_fifo.sv
// Synchronous PCM sample FIFO; push and pop may coincide at any level,
// a push while full without a pop is refused.
module pcm_sample_fifo
    import pcm_dc_block_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     mclk1,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  pcm_t                     din,
    output pcm_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    pcm_t          mem_q [DEPTH];
    pcm_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // When full, a simultaneous pop frees the very slot being written.
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign level = count_q;

endmodule

// File: rtl/pcm_dc_block_fifo.sv
// Post-decimator audio stage: first-order DC-blocking high-pass, power-of-two
// gain with saturation to signed 16-bit PCM, and an output sample FIFO.
module pcm_dc_block_fifo
    import pcm_dc_block_fifo_pkg::*;
#(
    parameter int DC_K       = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int ACC_FRAC   = 8
) (
    input  logic                          mclk1,
    input  logic                          reset,
    pcm_dc_block_fifo_if.slave            bus,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int X_W  = PCM_W + 1;
    localparam int DX_W = X_W + 1;
    localparam int Y_W  = X_W + ACC_FRAC + DC_K;
    localparam int Q_W  = Y_W - ACC_FRAC;
    localparam int P_W  = Q_W + 7;

    logic signed [X_W-1:0]  x_prev_q, x_prev_d;
    logic signed [Y_W-1:0]  y_q, y_d;
    logic [2:0]             gain_q, gain_d;
    logic                   s1_vld_q, s1_vld_d;
    pcm_t                   s2_pcm_q, s2_pcm_d;
    logic                   s2_vld_q, s2_vld_d;
    logic                   push_q, push_d;
    logic                   ovf_q, ovf_d;

    logic signed [X_W-1:0]  x_new;
    logic signed [DX_W-1:0] dx;
    logic signed [Y_W-1:0]  y_new;
    logic signed [Q_W-1:0]  q;
    logic signed [P_W-1:0]  p;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    always_comb begin
        x_new = {1'b0, bus.in_data};
        dx    = DX_W'(x_new) - DX_W'(x_prev_q);
        // y carries enough headroom that this update never wraps.
        y_new = y_q + (Y_W'(dx) <<< ACC_FRAC) - (y_q >>> DC_K);

        x_prev_d = x_prev_q;
        y_d      = y_q;
        gain_d   = gain_q;
        s1_vld_d = bus.in_en;
        if (bus.in_en) begin
            x_prev_d = x_new;
            y_d      = y_new;
            gain_d   = bus.gain_sh;
        end

        // Dropping the fraction bits of y is a floor, i.e. toward -inf.
        q        = y_q[Y_W-1:ACC_FRAC];
        p        = P_W'(q) <<< gain_q;
        s2_vld_d = s1_vld_q;
        s2_pcm_d = s1_vld_q ? sat16(SAT_IN_W'(p)) : s2_pcm_q;
        push_d   = s2_vld_q;

        pop   = !fifo_empty && bus.out_ready;
        ovf_d = ovf_q;
        if (push_q && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            x_prev_q <= '0;
            y_q      <= '0;
            gain_q   <= '0;
            s1_vld_q <= 1'b0;
            s2_pcm_q <= '0;
            s2_vld_q <= 1'b0;
            push_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            x_prev_q <= x_prev_d;
            y_q      <= y_d;
            gain_q   <= gain_d;
            s1_vld_q <= s1_vld_d;
            s2_pcm_q <= s2_pcm_d;
            s2_vld_q <= s2_vld_d;
            push_q   <= push_d;
            ovf_q    <= ovf_d;
        end
    end

    // s2_pcm_q holds until the next sample reaches stage 2, which the minimum
    // strobe spacing keeps later than this push.
    pcm_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .mclk1 (mclk1),
        .reset (reset),
        .push  (push_q),
        .pop   (bus.out_ready),
        .din   (s2_pcm_q),
        .dout  (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bus.out_valid = !fifo_empty;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_pcm_dc_block_fifo.sv
// Bench for pcm_dc_block_fifo: table of single-sample vectors, directed corner
// sequences, and random traffic against a queue-based reference model.
module tb_pcm_dc_block_fifo;

    localparam int DC_K       = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int ACC_FRAC   = 8;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic          mclk1;
    logic          reset;
    logic          ovf;
    logic          ovf_clr;
    logic [LW-1:0] level;

    pcm_dc_block_fifo_if ifc ();

    pcm_dc_block_fifo #(
        .DC_K       (DC_K),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ACC_FRAC   (ACC_FRAC)
    ) dut (
        .mclk1   (mclk1),
        .reset   (reset),
        .bus     (ifc),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .level   (level)
    );

    initial mclk1 = 1'b0;
    always #5 mclk1 = ~mclk1;

    typedef struct {
        int din;
        int g;
        int exp;
    } vec_t;

    vec_t   vecs [8];
    int     ov_exp [8];
    int     n_checks = 0;
    int     n_err    = 0;

    // Reference model state: filter, 3-edge latency line, FIFO queue, flag.
    longint m_y;
    longint m_xd;
    bit     m_dl_v [3];
    longint m_dl_d [3];
    longint m_q [$];
    bit     m_ovf;
    longint popped [$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_y  = 0;
        m_xd = 0;
        for (int i = 0; i < 3; i++) begin
            m_dl_v[i] = 1'b0;
            m_dl_d[i] = 0;
        end
        m_q.delete();
        m_ovf = 1'b0;
        popped.delete();
    endfunction

    function automatic longint model_filter(input int x, input int g);
        longint qv;
        longint pv;
        m_y  = m_y + (longint'(x) - m_xd) * longint'(2 ** ACC_FRAC) - (m_y >>> DC_K);
        m_xd = longint'(x);
        qv   = m_y >>> ACC_FRAC;
        pv   = qv * (longint'(1) << g);
        if (pv > 32767)  pv = 32767;
        if (pv < -32768) pv = -32768;
        return pv;
    endfunction

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic cyc(input bit en, input int d, input int g, input bit rdy,
                       input bit clr, input bit check);
        bit     pop;
        bit     wr_v;
        bit     set;
        longint wr_d;
        int     sz;
        ifc.in_en     = en;
        ifc.in_data   = 16'(d);
        ifc.gain_sh   = 3'(g);
        ifc.out_ready = rdy;
        ovf_clr       = clr;
        if (ifc.out_valid && rdy) popped.push_back(longint'(ifc.out_data));
        @(posedge mclk1);
        sz   = m_q.size();
        pop  = (sz > 0) && rdy;
        wr_v = m_dl_v[2];
        wr_d = m_dl_d[2];
        m_dl_v[2] = m_dl_v[1];
        m_dl_d[2] = m_dl_d[1];
        m_dl_v[1] = m_dl_v[0];
        m_dl_d[1] = m_dl_d[0];
        m_dl_v[0] = en;
        m_dl_d[0] = 0;
        if (en) m_dl_d[0] = model_filter(d, g);
        set = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (wr_v) begin
            if (sz == FIFO_DEPTH && !pop) set = 1'b1;
            else m_q.push_back(wr_d);
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        if (check) begin
            chk("valid", longint'(ifc.out_valid), longint'(m_q.size() > 0));
            chk("level", longint'(level), longint'(m_q.size()));
            chk("ovf", longint'(ovf), longint'(m_ovf));
            if (m_q.size() > 0) chk("data", longint'(ifc.out_data), m_q[0]);
        end
    endtask

    task automatic send(input int d, input int g, input bit rdy);
        cyc(1'b1, d, g, rdy, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, d, g, rdy, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input bit check_state);
        ifc.in_en     = 1'b0;
        ifc.in_data   = '0;
        ifc.gain_sh   = '0;
        ifc.out_ready = 1'b0;
        ovf_clr       = 1'b0;
        reset         = 1'b1;
        model_clear();
        #1;
        if (check_state) begin
            chk("rst_valid", longint'(ifc.out_valid), 0);
            chk("rst_level", longint'(level), 0);
            chk("rst_ovf", longint'(ovf), 0);
            chk("rst_data", longint'(ifc.out_data), 0);
        end
        repeat (2) @(posedge mclk1);
        #1 reset = 1'b0;
    endtask

    initial begin
        longint last;
        int     gap;
        bit     en_r;
        bit     rdy_r;

        vecs[0] = '{din: 500,   g: 0, exp: 500};
        vecs[1] = '{din: 1000,  g: 0, exp: 1000};
        vecs[2] = '{din: 16000, g: 4, exp: 32767};
        vecs[3] = '{din: 4095,  g: 3, exp: 32760};
        vecs[4] = '{din: 65535, g: 0, exp: 32767};
        vecs[5] = '{din: 0,     g: 5, exp: 0};
        vecs[6] = '{din: 1,     g: 7, exp: 128};
        vecs[7] = '{din: 12345, g: 1, exp: 24690};
        // Ramp 1..8 through the filter: decay of y>>>10 starts at the 5th sample.
        ov_exp = '{1, 2, 3, 4, 4, 5, 6, 7};

        reset   = 1'b0;
        ovf_clr = 1'b0;
        #2;
        do_reset(1'b1);

        // First sample after reset: x_d = 0, so output = sat(x << g), 3 edges later.
        for (int i = 0; i < 8; i++) begin
            do_reset(1'b0);
            cyc(1'b1, vecs[i].din, vecs[i].g, 1'b0, 1'b0, 1'b1);
            repeat (2) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
            chk("lat_not_early", longint'(ifc.out_valid), 0);
            cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
            chk("lat_valid", longint'(ifc.out_valid), 1);
            chk("lat_data", longint'(ifc.out_data), longint'(vecs[i].exp));
            repeat (3) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
            chk("hold_valid", longint'(ifc.out_valid), 1);
            chk("hold_data", longint'(ifc.out_data), longint'(vecs[i].exp));
            cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
            chk("pop_drops_valid", longint'(ifc.out_valid), 0);
        end

        // Step response.
        do_reset(1'b0);
        for (int i = 0; i < 8000; i++) send(1000, 0, 1'b1);
        repeat (2) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("step_count", longint'(popped.size()), 8000);
        if (popped.size() >= 3) begin
            chk("step_out0", popped[0], 1000);
            chk("step_out1", popped[1], 999);
            chk("step_out2", popped[2], 998);
            last = popped[popped.size()-1];
            // Floor truncation parks y below 2^DC_K, i.e. |out| < 2^(DC_K-ACC_FRAC).
            chk("step_tail_small", longint'(last >= -3 && last <= 3), 1);
        end

        // Saturation both ways.
        do_reset(1'b0);
        for (int i = 0; i < 200; i++) send(16000, 4, 1'b1);
        send(0, 4, 1'b1);
        repeat (2) cyc(1'b0, 0, 4, 1'b1, 1'b0, 1'b1);
        chk("sat_count", longint'(popped.size()), 201);
        if (popped.size() == 201) begin
            chk("sat_pos", popped[0], 32767);
            chk("sat_neg", popped[200], -32768);
        end

        // Overflow, clear, set-beats-clear, ordered drain.
        do_reset(1'b0);
        for (int v = 1; v <= 10; v++) send(v, 0, 1'b0);
        chk("ovf_level_full", longint'(level), 8);
        chk("ovf_set", longint'(ovf), 1);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("ovf_cleared", longint'(ovf), 0);
        cyc(1'b1, 11, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("ovf_set_wins", longint'(ovf), 1);
        repeat (8) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("ovf_drain_count", longint'(popped.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < popped.size()) chk("ovf_drain_data", popped[i], longint'(ov_exp[i]));
        end
        chk("ovf_drain_level", longint'(level), 0);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("ovf_clr_after", longint'(ovf), 0);

        // Full FIFO with push and pop on the same edge.
        do_reset(1'b0);
        for (int v = 1; v <= 8; v++) send(v * 300, 0, 1'b0);
        chk("full_level", longint'(level), 8);
        cyc(1'b1, 5000, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("full_pushpop_level", longint'(level), 8);
        chk("full_pushpop_ovf", longint'(ovf), 0);
        repeat (8) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("full_pushpop_count", longint'(popped.size()), 9);

        // Reset with entries queued and a sample in flight.
        do_reset(1'b0);
        for (int v = 1; v <= 5; v++) send(v * 100, 0, 1'b0);
        cyc(1'b1, 900, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 900, 0, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", longint'(ifc.out_valid), 0);
        chk("midrst_level", longint'(level), 0);
        model_clear();
        repeat (2) @(posedge mclk1);
        #1 reset = 1'b0;
        send(700, 0, 1'b0);
        chk("midrst_next_valid", longint'(ifc.out_valid), 1);
        chk("midrst_next_data", longint'(ifc.out_data), 700);

        // Random traffic with alternating sink pressure.
        do_reset(1'b0);
        gap = 0;
        for (int c = 0; c < 3000; c++) begin
            en_r = 1'b0;
            if (gap == 0) begin
                en_r = 1'b1;
                gap  = int'($urandom_range(3, 9)) - 1;
            end else begin
                gap--;
            end
            if (((c / 256) % 2) == 1) rdy_r = ($urandom_range(0, 3) != 0);
            else rdy_r = ($urandom_range(0, 4) == 0);
            cyc(en_r, int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)), rdy_r,
                ($urandom_range(0, 40) == 0), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
